mips_raw_scoreboard: RTL
========================

Name: mips_raw_scoreboard

Overview:
- Parametrised RAW-hazard interlock for the MIPS_32 pipeline. Makes hand-inserted dummy OR instructions unnecessary between dependent instructions.
- Tracks destination registers of instructions in flight for LAT cycles and stalls issue of any instruction whose source register is still pending.
- Sits between decode and issue; drives the stall and writeback-tag signals.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NREG.
- LAT, 3, cycles from accepted issue to register writeback; legal range 1..8.

Ports:
- clk  in  1  single pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_wr_en  in  1  instruction writes a destination register.
- issue_rd  in  ADDR_W  destination register index.
- issue_rs  in  ADDR_W  source register 1.
- issue_rt  in  ADDR_W  source register 2.
- use_rs  in  1  rs is read by this instruction.
- use_rt  in  1  rt is read by this instruction.
- halt  in  1  HLT decoded; blocks all further issue.
- flush  in  1  branch taken; discard all tracked entries.
- stall  out  1  combinational; instruction must be held this cycle.
- wb_valid  out  1  final stage holds a live write.
- wb_rd  out  ADDR_W  register written by the final stage.
- pending_cnt  out  $clog2(LAT+1)  number of valid stages.
- fwd_rs  out  1  rs is supplied by the final-stage bypass (feature only).
- fwd_rt  out  1  rt is supplied by the final-stage bypass (feature only).

Behaviour:
- State is a shift pipe of LAT entries {v, rd}, pipe[0] youngest, pipe[LAT-1] oldest.
- Reset (rst_n low, asynchronous) clears all v bits. Outputs during reset: stall=0, wb_valid=0, wb_rd=0, pending_cnt=0, fwd_rs=fwd_rt=0.
- Reset mid-operation drops all entries; no writeback is reported for them.
- hit(r,i) = pipe[i].v && pipe[i].rd==r && r!=0.
- stall = issue_valid && (halt || (use_rs && any hit(issue_rs,i)) || (use_rt && any hit(issue_rt,i))). With the feature compiled in, final-stage hits are excluded from this term.
- Accept = issue_valid && !stall && !flush.
- Each rising edge: pipe[i] <= pipe[i-1] for i>=1.
- pipe[0] <= {Accept && issue_wr_en && issue_rd!=0, issue_rd}. A stall inserts a bubble (v=0) into pipe[0].
- Latency: an instruction accepted in cycle t occupies pipe[k] during cycle t+1+k. Its rd is busy in cycles t+1..t+LAT. A dependent instruction is accepted no earlier than cycle t+LAT+1.
- wb_valid and wb_rd are driven directly from pipe[LAT-1] (registered).
- pending_cnt is the popcount of the v bits, updated with the pipe.
- flush has priority: on that edge every v bit clears, including the same-cycle issue, which is discarded and not accepted.
- halt held high: stall follows issue_valid, the pipe drains to pending_cnt=0 in LAT cycles, and no new entries enter.
- The same rd may occupy several stages (WAW). Busy status holds until the last copy leaves.
- Self-dependence, e.g. rd==rs on the same instruction, never stalls on itself.
- issue_rd, issue_rs and issue_rt values >= NREG are treated as no-hit.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined: hits only in pipe[LAT-1] do not stall, and fwd_rs/fwd_rt assert, combinationally, for a used source matching wb_rd. A hit in any younger stage still stalls and forces fwd_rs/fwd_rt=0. Dependent instruction is accepted at cycle t+LAT.
- Undefined: fwd_rs/fwd_rt are tied 0 and all hits stall.

Test Plan:
- RAW stall (LAT=3): ADDI R1 issued cycle 0, ADD R4,R1,R2 presented from cycle 1 -> stall=1 in cycles 1-3, accepted cycle 4. wb_valid=1 with wb_rd=1 in cycle 3.
- Independent back-to-back: ADDI R1, R2, R3 in cycles 0,1,2 -> stall never asserts, pending_cnt=3 in cycle 3. wb_rd is 1,2,3 in cycles 3,4,5.
- Register 0: writes to R0 then a read of R0 -> no entry created, pending_cnt stays 0, stall=0.
- Flush: three writes in flight, flush=1 in cycle 3 with issue_valid=1 -> pending_cnt=0 and wb_valid=0 in cycle 4, the cycle-3 instruction not tracked. Repeat with rst_n pulsed low mid-stream -> same cleared state immediately.
- Halt drain: halt=1 with 2 entries pending -> stall=1 while issue_valid, pending_cnt goes 2,1,0, no new entries.
- SCOREBOARD_FWD_EN, same stimulus as the RAW stall case -> stall=1 only in cycles 1-2. Accepted cycle 3 with fwd_rs=1; fwd_rs=0 in all other cycles.

Source files
------------

// File: rtl/mips_raw_scoreboard.sv
// mips_raw_scoreboard: RAW-hazard interlock tracking in-flight destination registers for LAT cycles.
// Define SCOREBOARD_FWD_EN to let final-stage hits bypass instead of stall.
module mips_raw_scoreboard #(
  parameter int NREG = 32,
  parameter int ADDR_W = 5,
  parameter int LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic                       issue_wr_en,
  input  logic [ADDR_W-1:0]          issue_rd,
  input  logic [ADDR_W-1:0]          issue_rs,
  input  logic [ADDR_W-1:0]          issue_rt,
  input  logic                       use_rs,
  input  logic                       use_rt,
  input  logic                       halt,
  input  logic                       flush,
  output logic                       stall,
  output logic                       wb_valid,
  output logic [ADDR_W-1:0]          wb_rd,
  output logic [$clog2(LAT+1)-1:0]   pending_cnt,
  output logic                       fwd_rs,
  output logic                       fwd_rt
);
  localparam int CW = $clog2(LAT+1);
  localparam logic [LAT-1:0] OLD = LAT'(1) << (LAT-1);
  localparam bit FULL = NREG >= (1 << ADDR_W);
  logic [LAT-1:0] v, hs, ht;
  logic [LAT-1:0][ADDR_W-1:0] rd;
  logic blk_rs, blk_rt, accept;
  // R0 and indices beyond the register file never match
  function automatic logic ok(input logic [ADDR_W-1:0] r);
    return r != '0 && (FULL || 32'(r) < NREG);
  endfunction
  always_comb begin
    hs = '0;
    ht = '0;
    for (int i = 0; i < LAT; i++) begin
      hs[i] = v[i] && rd[i] == issue_rs && ok(issue_rs);
      ht[i] = v[i] && rd[i] == issue_rt && ok(issue_rt);
    end
`ifdef SCOREBOARD_FWD_EN
    blk_rs = |(hs & ~OLD);
    blk_rt = |(ht & ~OLD);
    fwd_rs = rst_n && issue_valid && use_rs && hs[LAT-1] && !blk_rs;
    fwd_rt = rst_n && issue_valid && use_rt && ht[LAT-1] && !blk_rt;
`else
    blk_rs = |hs;
    blk_rt = |ht;
    fwd_rs = 1'b0;
    fwd_rt = 1'b0;
`endif
    stall = rst_n && issue_valid && (halt || (use_rs && blk_rs) || (use_rt && blk_rt));
    accept = issue_valid && !stall && !flush;
    pending_cnt = '0;
    for (int i = 0; i < LAT; i++) pending_cnt += CW'(v[i]);
  end
  assign wb_valid = v[LAT-1];
  assign wb_rd = rd[LAT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      rd <= '0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        v[i] <= v[i-1] && !flush;
        rd[i] <= rd[i-1];
      end
      v[0] <= accept && issue_wr_en && ok(issue_rd);
      rd[0] <= issue_rd;
    end
  end
endmodule
